obstacle_field: RTL

Parametrised obstacle generator for the flappy-style game. It is the generalised successor to the fixed 8-bar environment. Each of NUM_BARS vertical bars carries an opening: a top position plus a height. Each update, every moving bar advances by a level-scaled step, in one of two modes:
- **Wrap mode**: the bar wraps to the top and draws a new pseudo-random opening height.
- **Bounce mode**: the bar reverses direction at the screen edges.

The block feeds the renderer and collision logic, and pulses per-bar events for scoring.

---
 rtl/obstacle_field.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_field.sv
// ----------------------------------------------------------------------------
// obstacle_field
//   Parametrised obstacle generator for a flappy-style game. NUM_BARS vertical
//   bars each carry an opening (top position + height). On every update a
//   moving bar advances by a level-scaled step. In wrap mode it returns to the
//   top and draws a new opening height. In bounce mode it reverses direction
//   at the screen edges. A per-bar event pulse marks each wrap or bounce.
//
// Ports
//   clkenv    in   block clock, rising edge
//   rst       in   synchronous active-high reset
//   pause     in   freezes all bar state (the LFSR keeps running)
//   mode      in   0 = wrap, 1 = bounce
//   level     in   speed multiplier; 0 stops all motion
//   bar_pos   out  top of opening, bar i in [i*POS_W +: POS_W]
//   bar_op    out  opening height, packed like bar_pos
//   bar_event out  one-cycle pulse per bar on wrap / bounce
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// obstacle_bar
//   State and update rule for one bar. The speed and the LFSR salt are
//   elaboration-time constants derived from the bar index.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   pause_i    hold request
//   mode_i     0 = wrap, 1 = bounce
//   level_i    speed multiplier
//   lfsr_lo_i  low bits of the shared LFSR, used for reseeding
//   pos_o      registered top of opening
//   op_o       registered opening height
//   ev_o       registered wrap/bounce pulse
// ----------------------------------------------------------------------------
module obstacle_bar #(
    parameter int unsigned POS_W           = 10,
    parameter int unsigned LEVEL_W         = 10,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned SPEED           = 20,
    parameter int unsigned IDX             = 0,
    parameter int unsigned INIT_POS        = 120,
    parameter int unsigned INIT_OPEN       = 60,
    parameter int unsigned MIN_OPEN        = 40,
    parameter int unsigned OPEN_RANGE_LOG2 = 5,
    parameter bit          IS_STATIC       = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pause_i,
    input  logic                       mode_i,
    input  logic [LEVEL_W-1:0]         level_i,
    input  logic [OPEN_RANGE_LOG2-1:0] lfsr_lo_i,
    output logic [POS_W-1:0]           pos_o,
    output logic [POS_W-1:0]           op_o,
    output logic                       ev_o
);
    // Arithmetic width wide enough that speed*level never truncates.
    localparam int unsigned RW = POS_W + LEVEL_W + 1;

    localparam logic [RW-1:0] SPEED_V  = RW'(SPEED);
    localparam logic [RW-1:0] SCREEN_V = RW'(SCREEN_H);

    // Per-bar salt so bars reseeding on the same cycle draw different heights.
    localparam logic [31:0] SALT_FULL = 32'(IDX) * 32'h0000_9E37;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] op_q,  op_d;
    logic             dir_q, dir_d;   // 0 = moving down, 1 = moving up
    logic             ev_q,  ev_d;

    logic [RW-1:0]              raw;
    logic [RW-1:0]              step;
    logic [RW-1:0]              limit;
    logic [RW-1:0]              sum;
    logic [OPEN_RANGE_LOG2-1:0] rnd_lo;
    logic                       upd;

    always_comb begin
        raw    = SPEED_V * RW'(level_i);
        // A step larger than the screen behaves the same as a full-screen step.
        step   = (raw > SCREEN_V) ? SCREEN_V : raw;
        limit  = SCREEN_V - RW'(op_q);
        sum    = RW'(pos_q) + step;
        rnd_lo = lfsr_lo_i ^ SALT_FULL[OPEN_RANGE_LOG2-1:0];
        upd    = !pause_i && !IS_STATIC && (step != '0);
    end

    always_comb begin
        pos_d = pos_q;
        op_d  = op_q;
        dir_d = dir_q;
        ev_d  = 1'b0;
        if (upd) begin
            if (!mode_i) begin
                // Wrap: always travels down, dir is left alone so a later
                // switch back to bounce resumes the old direction.
                if (sum > limit) begin
                    pos_d = '0;
                    op_d  = POS_W'(MIN_OPEN) + POS_W'(rnd_lo);
                    ev_d  = 1'b1;
                end else begin
                    pos_d = sum[POS_W-1:0];
                end
            end else if (!dir_q) begin
                if (sum >= limit) begin
                    pos_d = limit[POS_W-1:0];
                    dir_d = 1'b1;
                    ev_d  = 1'b1;
                end else begin
                    pos_d = sum[POS_W-1:0];
                end
            end else begin
                if (RW'(pos_q) <= step) begin
                    pos_d = '0;
                    dir_d = 1'b0;
                    ev_d  = 1'b1;
                end else begin
                    // step < pos here, so it fits in POS_W bits.
                    pos_d = pos_q - step[POS_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= POS_W'(INIT_POS);
            op_q  <= POS_W'(INIT_OPEN);
            dir_q <= 1'b0;
            ev_q  <= 1'b0;
        end else begin
            pos_q <= pos_d;
            op_q  <= op_d;
            dir_q <= dir_d;
            ev_q  <= ev_d;
        end
    end

    assign pos_o = pos_q;
    assign op_o  = op_q;
    assign ev_o  = ev_q;
endmodule

module obstacle_field #(
    parameter int unsigned          NUM_BARS        = 8,
    parameter int unsigned          POS_W           = 10,
    parameter int unsigned          LEVEL_W         = 10,
    parameter int unsigned          SCREEN_H        = 480,
    parameter int unsigned          BASE_SPEED      = 20,
    parameter int unsigned          SPEED_INC       = 0,
    parameter int unsigned          INIT_POS        = 120,
    parameter int unsigned          INIT_OPEN       = 60,
    parameter int unsigned          MIN_OPEN        = 40,
    parameter int unsigned          OPEN_RANGE_LOG2 = 5,
    parameter logic [NUM_BARS-1:0]  STATIC_MASK     = NUM_BARS'(8'h81),
    parameter logic [15:0]          SEED            = 16'hACE1
) (
    input  logic                      clkenv,
    input  logic                      rst,
    input  logic                      pause,
    input  logic                      mode,
    input  logic [LEVEL_W-1:0]        level,
    output logic [NUM_BARS*POS_W-1:0] bar_pos,
    output logic [NUM_BARS*POS_W-1:0] bar_op,
    output logic [NUM_BARS-1:0]       bar_event
);
    // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form. It runs on
    // every non-reset cycle, pause included, so a pause perturbs later reseeds.
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clkenv) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    // Packed so element i lands exactly at [i*POS_W +: POS_W].
    logic [NUM_BARS-1:0][POS_W-1:0] pos_w;
    logic [NUM_BARS-1:0][POS_W-1:0] op_w;
    logic [NUM_BARS-1:0]            ev_w;

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
        obstacle_bar #(
            .POS_W          (POS_W),
            .LEVEL_W        (LEVEL_W),
            .SCREEN_H       (SCREEN_H),
            .SPEED          (BASE_SPEED + i * SPEED_INC),
            .IDX            (i),
            .INIT_POS       (INIT_POS),
            .INIT_OPEN      (INIT_OPEN),
            .MIN_OPEN       (MIN_OPEN),
            .OPEN_RANGE_LOG2(OPEN_RANGE_LOG2),
            .IS_STATIC      (STATIC_MASK[i])
        ) u_bar (
            .clk_i    (clkenv),
            .rst_i    (rst),
            .pause_i  (pause),
            .mode_i   (mode),
            .level_i  (level),
            .lfsr_lo_i(lfsr_q[OPEN_RANGE_LOG2-1:0]),
            .pos_o    (pos_w[i]),
            .op_o     (op_w[i]),
            .ev_o     (ev_w[i])
        );
    end

    assign bar_pos   = pos_w;
    assign bar_op    = op_w;
    assign bar_event = ev_w;
endmodule
